pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Sequencing controller for the 4-stage pipelined datapath (IF, ID, EX/MEM, WB). It decides each cycle whether the PC and IF/ID buffer advance, stall or flush, and whether a bubble enters the ID/EX buffer. It resolves register read-after-write hazards with an internal shadow scoreboard, flushes on taken branches and jumps, and handles start/halt with a drain sequence. It sits beside the datapath and drives the enables of the PC, IF/ID and ID/EX buffers.

## Interface
- FLUSH_CYCLES, 1, cycles of bubble after a PC change (legal 1–3)
- REG_AW, 6, register address width (instruction fields [27:22], [21:16], [15:10])
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE or HALT
- halt_req  in  1  level; request to stop fetching and drain
- id_rd, id_rs, id_rt  in  REG_AW each  register fields of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_regwrt  in  1  ID instruction writes rd (regWrt from control)
- ex_pc_change  in  1  PCChange from EX (jump, or taken Z/N branch)
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID buffer load enable
- ifid_flush  out  1  IF/ID contents replaced by a NOP
- idex_bubble  out  1  ID/EX control bits forced to 0
- stall  out  1  RAW hazard stall is active this cycle
- state  out  3  current FSM state
- stall_cnt, flush_cnt  out  32 each  present only with HAZARD_CTRL_PERF_EN

## Operation
- States: IDLE=0, RUN=1, FLUSH=2, DRAIN=3, HALT=4. Reset enters IDLE. Encodings 5–7 are unreachable and return to IDLE.
- Shadow scoreboard has two entries, EXs and WBs, each holding (valid, rd).
  - Each cycle: EXs <= idex_bubble ? invalid : (id_regwrt, id_rd); WBs <= EXs.
  - In IDLE and HALT both entries are cleared.
- hazard = (id_uses_rs & match(id_rs)) | (id_uses_rt & match(id_rt)), where match(r) is true if EXs or WBs is valid with rd == r. All 64 registers are real; register 0 also hazards. The WB-stage match exists because the register file write and read are not same-cycle bypassed.
- IDLE and HALT outputs: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1. `start` moves the FSM to RUN.
- RUN priority is ex_pc_change > halt_req > hazard.
  - ex_pc_change: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, stall=0. Go to FLUSH if FLUSH_CYCLES>1, otherwise stay in RUN.
  - halt_req: pc_write=0, ifid_write=0, idex_bubble=1. Go to DRAIN.
  - hazard: pc_write=0, ifid_write=0, idex_bubble=1, stall=1. Stay in RUN.
  - none: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1 for FLUSH_CYCLES−1 cycles, using a down-counter. Then return to RUN. ex_pc_change arriving in FLUSH reloads the counter.
- DRAIN: pc_write=0, ifid_write=0, idex_bubble=1 for exactly 2 cycles so in-flight EX and WB work completes. Then go to HALT. halt_req is ignored once DRAIN is entered.
- `start` in RUN, FLUSH or DRAIN is ignored.

## Timing
- All enables and stall are combinational from state, shadow and ID/EX inputs in the same cycle. There is no added latency.
- A RAW hazard on an instruction just issued stalls for at most 2 cycles: 2 when the match is in EXs, 1 when it is in WBs.
- A taken branch costs FLUSH_CYCLES bubble cycles.
- Reset values: state=IDLE, pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, stall=0, shadow invalid, counters 0.
- rst asserted mid-operation returns all of the above values immediately, without waiting for a clock edge.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - stall_cnt increments each cycle stall=1.
  - flush_cnt increments each cycle ifid_flush=1 while in RUN or FLUSH.
  - Both saturate at 32'hFFFFFFFF and clear only on rst.
- HAZARD_CTRL_PERF_EN undefined: the counters and their ports do not exist.

## Structure
- Shared package holds the state enum, REG_AW, and the opcode width (4) with its field positions.
- One sub-module, hazard_scoreboard, contains the two shadow entries and the compare logic and outputs hazard. The FSM and counters stay in the top module.

## Test plan
- Reset, then start; ID has no sources. Required: state=RUN on the next cycle and pc_write=1 steadily.
- Issue id_rd=5 with id_regwrt=1, then next cycle id_rs=5 with id_uses_rs=1. Required: stall=1 for 2 cycles with idex_bubble=1, then advance.
- Dependency at distance 2 (one independent instruction between). Required: exactly 1 stall cycle.
- ex_pc_change in the same cycle as a hazard, FLUSH_CYCLES=2. Required: ifid_flush=1 for 2 cycles, stall=0, and the EX shadow entry is invalidated.
- halt_req in RUN. Required: DRAIN for 2 cycles, then HALT with pc_write=0. A start pulse then returns to RUN.
- rst asserted in FLUSH. Required: outputs take reset values immediately. With HAZARD_CTRL_PERF_EN, the counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// register address width and the instruction field layout.
package pipeline_hazard_ctrl_pkg;

   localparam int HAZ_REG_AW = 6;

   // Opcode is 4 bits at the top of the instruction word, then rd, rs, rt.
   localparam int OPC_W   = 4;
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;
   localparam int RD_MSB  = 27;
   localparam int RD_LSB  = 22;
   localparam int RS_MSB  = 21;
   localparam int RS_LSB  = 16;
   localparam int RT_MSB  = 15;
   localparam int RT_LSB  = 10;

   typedef logic [2:0] hazState_t;

   localparam hazState_t ST_IDLE  = 3'd0;
   localparam hazState_t ST_RUN   = 3'd1;
   localparam hazState_t ST_FLUSH = 3'd2;
   localparam hazState_t ST_DRAIN = 3'd3;
   localparam hazState_t ST_HALT  = 3'd4;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// Two-entry shadow of the destination registers in EX/MEM and WB, compared
// against the sources of the instruction in ID to flag read-after-write hazards.
module hazard_scoreboard
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = HAZ_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              idex_bubble,
   input  logic              id_regwrt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   output logic              hazard
);

   logic              exValid;
   logic [REG_AW-1:0] exRd;
   logic              wbValid;
   logic [REG_AW-1:0] wbRd;

   // WB entry is needed because the register file does not bypass a same-cycle write to a read.
   function automatic logic matchReg(input logic [REG_AW-1:0] r,
                                     input logic exV, input logic [REG_AW-1:0] exR,
                                     input logic wbV, input logic [REG_AW-1:0] wbR);
      return (exV && (exR == r)) || (wbV && (wbR == r));
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exValid <= 1'b0;
         exRd    <= '0;
         wbValid <= 1'b0;
         wbRd    <= '0;
      end else if (clear) begin
         exValid <= 1'b0;
         exRd    <= '0;
         wbValid <= 1'b0;
         wbRd    <= '0;
      end else begin
         exValid <= idex_bubble ? 1'b0 : id_regwrt;
         exRd    <= idex_bubble ? '0 : id_rd;
         wbValid <= exValid;
         wbRd    <= exRd;
      end
   end

   always_comb begin
      hazard = (id_uses_rs && matchReg(id_rs, exValid, exRd, wbValid, wbRd)) ||
               (id_uses_rt && matchReg(id_rt, exValid, exRd, wbValid, wbRd));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 4-stage pipeline: PC / IF/ID / ID/EX enables,
// RAW stalls, branch flush and start/halt drain. HAZARD_CTRL_PERF_EN adds counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int REG_AW       = HAZ_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt_req,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_regwrt,
   input  logic              ex_pc_change,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              stall,
   output logic [2:0]        state
`ifdef HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   hazState_t  curState;
   hazState_t  nextState;
   logic [1:0] flushCnt;
   logic [1:0] nextFlushCnt;
   logic       drainCnt;
   logic       nextDrainCnt;
   logic       hazard;
   logic       clearShadow;

   assign state       = curState;
   assign clearShadow = (curState == ST_IDLE) || (curState == ST_HALT);

   hazard_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .clear       (clearShadow),
      .idex_bubble (idex_bubble),
      .id_regwrt   (id_regwrt),
      .id_rd       (id_rd),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .hazard      (hazard)
   );

   always_comb begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      stall        = 1'b0;
      nextState    = curState;
      nextFlushCnt = flushCnt;
      nextDrainCnt = drainCnt;
      case (curState)
         ST_IDLE, ST_HALT: begin
            if (start) nextState = ST_RUN;
         end
         ST_RUN: begin
            if (ex_pc_change) begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  nextState    = ST_FLUSH;
                  nextFlushCnt = FLUSH_LOAD;
               end
            end else if (halt_req) begin
               ifid_flush   = 1'b0;
               nextState    = ST_DRAIN;
               nextDrainCnt = 1'b0;
            end else if (hazard) begin
               // Hold PC and IF/ID so the dependent instruction retries next cycle.
               ifid_flush = 1'b0;
               stall      = 1'b1;
            end else begin
               pc_write    = 1'b1;
               ifid_write  = 1'b1;
               ifid_flush  = 1'b0;
               idex_bubble = 1'b0;
            end
         end
         ST_FLUSH: begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            if (ex_pc_change)          nextFlushCnt = FLUSH_LOAD;
            else if (flushCnt <= 2'd1) nextState    = ST_RUN;
            else                       nextFlushCnt = flushCnt - 2'd1;
         end
         ST_DRAIN: begin
            ifid_flush = 1'b0;
            if (drainCnt) nextState    = ST_HALT;
            else          nextDrainCnt = 1'b1;
         end
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         curState <= ST_IDLE;
         flushCnt <= 2'd0;
         drainCnt <= 1'b0;
      end else begin
         curState <= nextState;
         flushCnt <= nextFlushCnt;
         drainCnt <= nextDrainCnt;
      end
   end

`ifdef HAZARD_CTRL_PERF_EN
   logic flushCounted;
   assign flushCounted = ifid_flush && ((curState == ST_RUN) || (curState == ST_FLUSH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (stall && (stall_cnt != 32'hFFFF_FFFF))        stall_cnt <= stall_cnt + 32'd1;
         if (flushCounted && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=2; covers
// HAZARD_CTRL_PERF_EN counters when that macro is defined.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, halt_req, id_uses_rs, id_uses_rt, id_regwrt, ex_pc_change;
   logic [5:0] id_rd, id_rs, id_rt;
   logic       pc_write, ifid_write, ifid_flush, idex_bubble, stall;
   logic [2:0] state;
`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int errors = 0;
   int checks = 0;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .REG_AW(6)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrt(id_regwrt),
      .ex_pc_change(ex_pc_change),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .stall(stall), .state(state)
`ifdef HAZARD_CTRL_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; halt_req = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_regwrt = 0; ex_pc_change = 0; id_rd = 0; id_rs = 0; id_rt = 0;
      cyc();
      @(negedge clk);
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write got=%b exp=0", pc_write); end
      checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL reset_ifid_write got=%b exp=0", ifid_write); end
      checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL reset_ifid_flush got=%b exp=1", ifid_flush); end
      checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL reset_idex_bubble got=%b exp=1", idex_bubble); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      @(negedge clk);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_state got=%0d exp=1", state); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL start_pc_write got=%b exp=1", pc_write); end
      cyc();
      @(negedge clk);
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL start_pc_write_steady got=%b exp=1", pc_write); end
      checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL start_idex_bubble got=%b exp=0", idex_bubble); end
   endtask

   task automatic test_raw_ex();
      id_rd = 6'd5; id_regwrt = 1'b1;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rawex_issue_stall got=%b exp=0", stall); end
      cyc();
      id_rd = 6'd0; id_regwrt = 1'b0; id_rs = 6'd5; id_uses_rs = 1'b1;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rawex_stall1 got=%b exp=1", stall); end
      checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL rawex_bubble1 got=%b exp=1", idex_bubble); end
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rawex_pc_write1 got=%b exp=0", pc_write); end
      cyc();
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rawex_stall2 got=%b exp=1", stall); end
      checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL rawex_bubble2 got=%b exp=1", idex_bubble); end
      cyc();
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rawex_release_stall got=%b exp=0", stall); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rawex_release_pc_write got=%b exp=1", pc_write); end
      checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL rawex_release_bubble got=%b exp=0", idex_bubble); end
      cyc();
      id_uses_rs = 1'b0;
   endtask

   task automatic test_raw_wb();
      id_rd = 6'd9; id_regwrt = 1'b1;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rawwb_issue_stall got=%b exp=0", stall); end
      cyc();
      id_rd = 6'd10;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rawwb_indep_stall got=%b exp=0", stall); end
      cyc();
      id_regwrt = 1'b0; id_rd = 6'd0; id_rs = 6'd9; id_uses_rs = 1'b1;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rawwb_stall got=%b exp=1", stall); end
      cyc();
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rawwb_release_stall got=%b exp=0", stall); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rawwb_release_pc_write got=%b exp=1", pc_write); end
      cyc();
      id_uses_rs = 1'b0;
   endtask

   task automatic test_reg0_rt();
      id_rd = 6'd0; id_regwrt = 1'b1;
      cyc();
      id_regwrt = 1'b0; id_rt = 6'd0; id_uses_rt = 1'b1;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reg0_rt_stall1 got=%b exp=1", stall); end
      cyc();
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reg0_rt_stall2 got=%b exp=1", stall); end
      cyc();
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reg0_rt_release got=%b exp=0", stall); end
      cyc();
      id_uses_rt = 1'b0;
   endtask

   task automatic test_flush_hazard();
      id_rd = 6'd5; id_regwrt = 1'b1;
      cyc();
      id_rd = 6'd7; id_rs = 6'd5; id_uses_rs = 1'b1; ex_pc_change = 1'b1;
      @(negedge clk);
      checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL flush_c1_ifid_flush got=%b exp=1", ifid_flush); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_c1_stall got=%b exp=0", stall); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL flush_c1_pc_write got=%b exp=1", pc_write); end
      checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL flush_c1_bubble got=%b exp=1", idex_bubble); end
      cyc();
      ex_pc_change = 1'b0; id_regwrt = 1'b0; id_uses_rs = 1'b0;
      @(negedge clk);
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL flush_c2_state got=%0d exp=2", state); end
      checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL flush_c2_ifid_flush got=%b exp=1", ifid_flush); end
      cyc();
      // rd=7 of the flushed instruction must not have been recorded.
      id_rs = 6'd7; id_uses_rs = 1'b1;
      @(negedge clk);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL flush_c3_state got=%0d exp=1", state); end
      checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL flush_c3_ifid_flush got=%b exp=0", ifid_flush); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_ex_invalidated got=%b exp=0", stall); end
      cyc();
      id_uses_rs = 1'b0;
   endtask

   task automatic test_halt();
      halt_req = 1'b1;
      @(negedge clk);
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL halt_req_pc_write got=%b exp=0", pc_write); end
      checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL halt_req_bubble got=%b exp=1", idex_bubble); end
      cyc();
      @(negedge clk);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL drain1_state got=%0d exp=3", state); end
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL drain1_pc_write got=%b exp=0", pc_write); end
      cyc();
      halt_req = 1'b0;
      @(negedge clk);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL drain2_state got=%0d exp=3", state); end
      cyc();
      @(negedge clk);
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL halt_state got=%0d exp=4", state); end
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL halt_pc_write got=%b exp=0", pc_write); end
      checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL halt_ifid_flush got=%b exp=1", ifid_flush); end
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      @(negedge clk);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL restart_state got=%0d exp=1", state); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL restart_pc_write got=%b exp=1", pc_write); end
      cyc();
   endtask

   task automatic test_rst_in_flush();
      ex_pc_change = 1'b1;
      cyc();
      ex_pc_change = 1'b0;
      @(negedge clk);
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL prerst_state got=%0d exp=2", state); end
`ifdef HAZARD_CTRL_PERF_EN
      checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL prerst_stall_cnt got=%0d exp=5", stall_cnt); end
      checks++; if (flush_cnt !== 32'd3) begin errors++; $display("FAIL prerst_flush_cnt got=%0d exp=3", flush_cnt); end
`endif
      #1 rst = 1'b1;
      #1;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL arst_state got=%0d exp=0", state); end
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL arst_pc_write got=%b exp=0", pc_write); end
      checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL arst_ifid_write got=%b exp=0", ifid_write); end
      checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL arst_ifid_flush got=%b exp=1", ifid_flush); end
      checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL arst_idex_bubble got=%b exp=1", idex_bubble); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall got=%b exp=0", stall); end
`ifdef HAZARD_CTRL_PERF_EN
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL arst_stall_cnt got=%0d exp=0", stall_cnt); end
      checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL arst_flush_cnt got=%0d exp=0", flush_cnt); end
`endif
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_start();
      test_raw_ex();
      test_raw_wb();
      test_reg0_rt();
      test_flush_hazard();
      test_halt();
      test_rst_in_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
